fifo_burst_sched: RTL and testbench
===================================

Name: fifo_burst_sched

Overview:
- Scheduler in front of the 8-bit prog_full/prog_empty FIFO used in the fifo exercise.
- Write side: round-robin arbitration between two burst-write requesters. Muxes the winner's data onto the FIFO data_v/data_in interface and stalls on prog_full.
- Read side: issues fixed-length read bursts (r_flag) when prog_empty is deasserted and the consumer is ready.
- Write and read sides run concurrently and independently.

Parameters:
- DW, 8, data width (matches FIFO data_in/dout).
- WR_LEN, 16, words per write burst (≥1).
- RD_LEN, 16, read strobes per read burst. Must be ≤ the FIFO prog_empty threshold.
- CNT_W, 8, burst counter width; 2**CNT_W > max(WR_LEN, RD_LEN).

Ports:
- sclk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  requester 0 has a WR_LEN-word burst pending.
- din0  in  DW  requester 0 current word.
- gnt0  out  1  requester 0 owns the write side for the whole burst.
- take0  out  1  din0 consumed this cycle; requester advances to next word.
- req1, din1, gnt1, take1: same as above, for requester 1.
- fifo_din  out  DW  to FIFO data_in.
- fifo_wr  out  1  to FIFO data_v.
- fifo_prog_full  in  1  FIFO prog_full.
- fifo_prog_empty  in  1  FIFO prog_empty.
- fifo_rd  out  1  to FIFO r_flag.
- rd_ready  in  1  consumer can accept a full RD_LEN burst.
- rd_done  out  1  one-cycle pulse after the last strobe of a read burst.
- busy  out  1  either FSM not idle.
- wr_cnt  out  32  words written (optional feature).
- rd_burst_cnt  out  16  read bursts completed (optional feature).

Behaviour:
- Reset: all outputs 0; write FSM in W_IDLE; read FSM in R_IDLE; round-robin pointer favours requester 0. Reset mid-burst abandons the burst immediately, with no further fifo_wr/fifo_rd.
- Write FSM W_IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester the pointer favours.
  - Load wcnt=WR_LEN; go to W_BURST. gnt is registered: high from the cycle after the grant decision.
- W_BURST:
  - takeN = gntN & ~fifo_prog_full (combinational).
  - On take: fifo_din <= dinN, fifo_wr <= 1 (registered, latency 1 cycle), wcnt decrements.
  - If fifo_prog_full=1: take=0, and fifo_wr=0 the next cycle. The burst stalls without losing a word.
  - The take with wcnt=1 ends the burst. Next cycle: gnt drops, the pointer flips to the other requester, back to W_IDLE. No new grant is issued in that same cycle (one idle cycle between bursts).
  - req deasserting mid-burst is ignored; the burst still completes WR_LEN words.
  - Exactly WR_LEN fifo_wr pulses occur per grant.
- Read FSM R_IDLE:
  - If ~fifo_prog_empty & rd_ready: go to R_BURST with rcnt=RD_LEN.
- R_BURST:
  - fifo_rd=1 (registered) for exactly RD_LEN consecutive cycles, regardless of rd_ready or prog_empty changes.
  - Then go to R_GAP with rd_done=1 for one cycle.
- R_GAP: lasts 1 cycle with fifo_rd=0 (lets prog_empty settle), then R_IDLE.
- Simultaneous FIFO write and read are permitted.
- busy = (write state != W_IDLE) | (read state != R_IDLE).

Optional Feature:
- Macro FIFO_SCHED_STATS_EN.
- Defined:
  - wr_cnt increments on every fifo_wr pulse, wrapping at 2^32.
  - rd_burst_cnt increments on every rd_done, wrapping at 2^16.
  - Both clear on rst.
- Undefined: both ports remain present and are tied to 0; no counter logic is synthesised.

Test Plan:
- Reset, then req0=1 alone with din0 incrementing 0x00.. on take0; prog_full=0 → gnt0 next cycle; 16 fifo_wr pulses carrying 0x00..0x0F; gnt0 drops; wr_cnt=16 (with macro).
- req0=req1=1 held for 3 bursts from reset → grants in order 0,1,0; one idle cycle between bursts; gnt0 and gnt1 never high together.
- During a req1 burst, force prog_full=1 for 5 cycles after word 4 → take1=0 and fifo_wr=0 for those cycles; words 4..15 arrive in order with no duplicates or drops; total 16 writes.
- prog_empty=0, rd_ready=1 → fifo_rd high for exactly 16 cycles; rd_done pulses on the next cycle; fifo_rd low for ≥1 cycle before the next burst. Deassert rd_ready mid-burst → the burst still finishes 16.
- Assert rst during write burst word 7 and read strobe 9 → next cycle gnt/fifo_wr/fifo_rd=0; busy=0; after release, req1 and req0 both high → req0 granted.
- Undefine FIFO_SCHED_STATS_EN, run scenario 1 → wr_cnt and rd_burst_cnt stay 0.

Source files
------------

// File: rtl/fifo_burst_sched.sv
// Burst scheduler in front of a prog_full/prog_empty FIFO: round-robin write bursts from two
// requesters plus fixed-length read bursts. Define FIFO_SCHED_STATS_EN for write/read-burst counters.
module fifo_burst_sched #(
    parameter int DW     = 8,
    parameter int WR_LEN = 16,
    parameter int RD_LEN = 16,
    parameter int CNT_W  = 8
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] din0,
    output logic          gnt0,
    output logic          take0,
    input  logic          req1,
    input  logic [DW-1:0] din1,
    output logic          gnt1,
    output logic          take1,
    output logic [DW-1:0] fifo_din,
    output logic          fifo_wr,
    input  logic          fifo_prog_full,
    input  logic          fifo_prog_empty,
    output logic          fifo_rd,
    input  logic          rd_ready,
    output logic          rd_done,
    output logic          busy,
    output logic [31:0]   wr_cnt,
    output logic [15:0]   rd_burst_cnt
);
    typedef enum logic {W_IDLE, W_BURST} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_BURST, R_GAP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [1:0]          req, gnt_q, take;
    logic [1:0][DW-1:0]  din;
    logic                own_q, ptr_q, grant_id, grant_go, burst_end, any_take;
    logic [CNT_W-1:0]    wcnt_q, rcnt_q;
    logic                rd_start, rd_last;

    assign req   = {req1, req0};
    assign din   = {din1, din0};
    // Gated by rst so a requester never advances on a word that reset discards.
    assign take  = gnt_q & {2{~fifo_prog_full & ~rst}};
    assign any_take = |take;
    assign gnt0  = gnt_q[0];
    assign gnt1  = gnt_q[1];
    assign take0 = take[0];
    assign take1 = take[1];
    assign busy  = (w_state != W_IDLE) | (r_state != R_IDLE);

    always_ff @(posedge sclk) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next    = w_state;
        grant_go  = 1'b0;
        grant_id  = 1'b0;
        burst_end = 1'b0;
        case (w_state)
            W_IDLE: if (|req) begin
                grant_go = 1'b1;
                grant_id = (&req) ? ptr_q : req[1];
                w_next   = W_BURST;
            end
            W_BURST: if (any_take && wcnt_q == CNT_W'(1)) begin
                burst_end = 1'b1;
                w_next    = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            gnt_q    <= '0;
            own_q    <= 1'b0;
            ptr_q    <= 1'b0;
            wcnt_q   <= '0;
            fifo_wr  <= 1'b0;
            fifo_din <= '0;
        end else begin
            fifo_wr <= any_take;
            if (any_take) begin
                fifo_din <= din[own_q];
                wcnt_q   <= wcnt_q - CNT_W'(1);
            end
            if (grant_go) begin
                own_q  <= grant_id;
                gnt_q  <= grant_id ? 2'b10 : 2'b01;
                wcnt_q <= CNT_W'(WR_LEN);
            end
            // Pointer favours the other requester once a burst completes.
            if (burst_end) begin
                gnt_q <= '0;
                ptr_q <= ~own_q;
            end
        end
    end

    always_comb begin
        r_next   = r_state;
        rd_start = 1'b0;
        rd_last  = 1'b0;
        case (r_state)
            R_IDLE: if (~fifo_prog_empty && rd_ready) begin
                rd_start = 1'b1;
                r_next   = R_BURST;
            end
            R_BURST: if (rcnt_q == CNT_W'(1)) begin
                rd_last = 1'b1;
                r_next  = R_GAP;
            end
            R_GAP:   r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            fifo_rd <= 1'b0;
            rd_done <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            fifo_rd <= rd_start | ((r_state == R_BURST) & ~rd_last);
            rd_done <= rd_last;
            if (rd_start)
                rcnt_q <= CNT_W'(RD_LEN);
            else if (r_state == R_BURST)
                rcnt_q <= rcnt_q - CNT_W'(1);
        end
    end

`ifdef FIFO_SCHED_STATS_EN
    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_cnt       <= '0;
            rd_burst_cnt <= '0;
        end else begin
            if (fifo_wr) wr_cnt <= wr_cnt + 32'd1;
            if (rd_done) rd_burst_cnt <= rd_burst_cnt + 16'd1;
        end
    end
`else
    assign wr_cnt       = '0;
    assign rd_burst_cnt = '0;
`endif
endmodule

// File: tb/tb_fifo_burst_sched.sv
// Directed bench for fifo_burst_sched: write bursts, round-robin, prog_full stall, read bursts, reset.
module tb_fifo_burst_sched;
`ifdef FIFO_SCHED_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        tb_sclk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        prog_full = 1'b0, prog_empty = 1'b1, rd_ready = 1'b0;
    logic [7:0]  d0 = 8'h00, d1 = 8'h00;
    logic [7:0]  din0, din1;
    logic        gnt0, gnt1, take0, take1, fifo_wr, fifo_rd, rd_done, busy;
    logic [7:0]  fifo_din;
    logic [31:0] wr_cnt;
    logic [15:0] rd_burst_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] wq[$];

    assign din0 = d0;
    assign din1 = d1 | 8'h80;

    fifo_burst_sched dut (
        .sclk(tb_sclk), .rst(rst),
        .req0(req0), .din0(din0), .gnt0(gnt0), .take0(take0),
        .req1(req1), .din1(din1), .gnt1(gnt1), .take1(take1),
        .fifo_din(fifo_din), .fifo_wr(fifo_wr),
        .fifo_prog_full(prog_full), .fifo_prog_empty(prog_empty),
        .fifo_rd(fifo_rd), .rd_ready(rd_ready), .rd_done(rd_done), .busy(busy),
        .wr_cnt(wr_cnt), .rd_burst_cnt(rd_burst_cnt)
    );

    always #5 tb_sclk = ~tb_sclk;

    // Requesters advance to their next word on each take.
    always @(posedge tb_sclk) begin
        if (rst) begin
            d0 <= 8'h00;
            d1 <= 8'h00;
        end else begin
            if (take0) d0 <= d0 + 8'h01;
            if (take1) d1 <= d1 + 8'h01;
        end
    end

    always @(posedge tb_sclk) if (fifo_wr) wq.push_back(fifo_din);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        prog_full = 1'b0; prog_empty = 1'b1; rd_ready = 1'b0;
        repeat (2) @(negedge tb_sclk);
        rst = 1'b0;
        wq.delete();
    endtask

    initial begin
        int nwr, ng, idle, found;
        int gid[3];
        logic [1:0] cur, g_prev;

        // Reset state
        repeat (2) @(negedge tb_sclk);
        chk("rst_gnt0", gnt0, 0);      chk("rst_gnt1", gnt1, 0);
        chk("rst_fifo_wr", fifo_wr, 0); chk("rst_fifo_rd", fifo_rd, 0);
        chk("rst_rd_done", rd_done, 0); chk("rst_busy", busy, 0);
        chk("rst_fifo_din", fifo_din, 0);
        chk("rst_wr_cnt", wr_cnt, 0);   chk("rst_rd_burst_cnt", rd_burst_cnt, 0);
        rst = 1'b0;

        // Scenario 1: single requester burst, req dropped mid-burst
        do_reset();
        req0 = 1'b1;
        @(negedge tb_sclk);
        chk("s1_gnt0", gnt0, 1); chk("s1_gnt1", gnt1, 0);
        req0 = 1'b0;
        nwr = 0;
        for (int i = 0; i < 24; i++) begin
            if (fifo_wr) begin
                chk("s1_data", fifo_din, nwr);
                nwr++;
            end
            @(negedge tb_sclk);
        end
        chk("s1_nwr", nwr, 16);
        chk("s1_gnt0_drop", gnt0, 0);
        chk("s1_busy", busy, 0);
        chk("s1_wr_cnt", wr_cnt, (STATS != 0) ? 16 : 0);
        chk("s1_rd_burst_cnt", rd_burst_cnt, 0);

        // Scenario 2: both requesting, grants 0,1,0 with one idle cycle between
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        g_prev = 2'b00; idle = 0; ng = 0; nwr = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge tb_sclk);
            cur = {gnt1, gnt0};
            chk("s2_no_overlap", gnt0 & gnt1, 0);
            if (cur != 2'b00 && g_prev == 2'b00) begin
                ng++;
                if (ng <= 3) gid[ng-1] = cur[1] ? 1 : 0;
                if (ng > 1) chk("s2_gap", idle, 1);
                if (ng == 3) begin req0 = 1'b0; req1 = 1'b0; end
            end
            idle   = (cur == 2'b00) ? idle + 1 : 0;
            g_prev = cur;
            if (fifo_wr) nwr++;
        end
        chk("s2_ngrants", ng, 3);
        chk("s2_order0", gid[0], 0);
        chk("s2_order1", gid[1], 1);
        chk("s2_order2", gid[2], 0);
        chk("s2_nwr", nwr, 48);

        // Scenario 3: prog_full stall for 5 cycles after word 4 of a req1 burst
        do_reset();
        req1 = 1'b1;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge tb_sclk);
            if (fifo_wr && fifo_din == 8'h84) found = 1;
        end
        chk("s3_word4_seen", found, 1);
        req1 = 1'b0;
        prog_full = 1'b1;
        repeat (5) begin
            #1;
            chk("s3_take1_stall", take1, 0);
            chk("s3_gnt1_hold", gnt1, 1);
            @(negedge tb_sclk);
            chk("s3_fifo_wr_stall", fifo_wr, 0);
        end
        prog_full = 1'b0;
        repeat (20) @(negedge tb_sclk);
        chk("s3_nwr", wq.size(), 16);
        for (int i = 0; i < 16; i++)
            if (i < wq.size()) chk("s3_data", wq[i], 8'h80 + i);
        chk("s3_wr_cnt", wr_cnt, (STATS != 0) ? 16 : 0);

        // Scenario 4: read burst of 16, rd_ready dropped mid-burst
        do_reset();
        prog_empty = 1'b0; rd_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge tb_sclk);
            chk("s4_rd_strobe", fifo_rd, 1);
            chk("s4_rd_done_early", rd_done, 0);
            if (i == 8) rd_ready = 1'b0;
        end
        @(negedge tb_sclk);
        chk("s4_rd_end", fifo_rd, 0);
        chk("s4_rd_done", rd_done, 1);
        @(negedge tb_sclk);
        chk("s4_gap_rd", fifo_rd, 0);
        chk("s4_rd_done_pulse", rd_done, 0);
        rd_ready = 1'b1;
        @(negedge tb_sclk);
        chk("s4_restart", fifo_rd, 1);
        chk("s4_busy", busy, 1);
        chk("s4_rd_burst_cnt", rd_burst_cnt, (STATS != 0) ? 1 : 0);

        // Scenario 5: reset at write word 7 / read strobe 9
        do_reset();
        req0 = 1'b1; prog_empty = 1'b0; rd_ready = 1'b1;
        repeat (9) @(negedge tb_sclk);
        chk("s5_word7", fifo_din, 8'h07);
        chk("s5_wr_pre", fifo_wr, 1);
        chk("s5_rd_pre", fifo_rd, 1);
        rst = 1'b1;
        @(negedge tb_sclk);
        chk("s5_gnt0", gnt0, 0);     chk("s5_gnt1", gnt1, 0);
        chk("s5_fifo_wr", fifo_wr, 0); chk("s5_fifo_rd", fifo_rd, 0);
        chk("s5_busy", busy, 0);
        req1 = 1'b1; prog_empty = 1'b1; rd_ready = 1'b0;
        rst = 1'b0;
        @(negedge tb_sclk);
        chk("s5_regrant0", gnt0, 1);
        chk("s5_regrant1", gnt1, 0);
        req0 = 1'b0; req1 = 1'b0;
        repeat (40) @(negedge tb_sclk);
        chk("s5_idle_after", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
